fp16_accum_stream: RTL and testbench



---
 rtl/fp16_pkg.sv | 20 ++
 rtl/fp16_add_core.sv | 63 ++++++
 rtl/fp16_accum_stream.sv | 100 ++++++++++
 tb/tb_fp16_accum_stream.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared half-precision field layout, special encodings and the accumulator
// FSM state type used by the convolution datapath stages.
package fp16_pkg;

    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 10;
    localparam int MAN_W    = 10;
    localparam int EXP_BIAS = 15;

    localparam logic [15:0] FP16_ZERO   = 16'h0000;
    localparam logic [15:0] FP16_MAXPOS = 16'h7BFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/fp16_add_core.sv
// Combinational fp16 adder: zero-flushing, truncating, saturating (no Inf/NaN).
// Shared by the accumulator and the later bias-add stage.
module fp16_add_core
    import fp16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s
);

    logic [4:0]        ea, eb, e_big, e_sm, shift;
    logic [10:0]       ma, mb, m_big, m_sm, m_sm_al, norm;
    logic              a_big, s_big, s_sm;
    logic [11:0]       raw;
    logic [3:0]        msb, lz;
    logic signed [6:0] exp_n;
    logic [9:0]        man;

    always_comb begin
        // exp 31 is folded to 30 so no Inf/NaN ever propagates
        ea = a[EXP_MSB:EXP_LSB];
        eb = b[EXP_MSB:EXP_LSB];
        if (ea == 5'd31) ea = 5'd30;
        if (eb == 5'd31) eb = 5'd30;
        ma = (ea == 5'd0) ? 11'd0 : {1'b1, a[MAN_W-1:0]};
        mb = (eb == 5'd0) ? 11'd0 : {1'b1, b[MAN_W-1:0]};

        // Order by magnitude so the subtraction below never goes negative
        a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
        e_big = a_big ? ea : eb;
        e_sm  = a_big ? eb : ea;
        m_big = a_big ? ma : mb;
        m_sm  = a_big ? mb : ma;
        s_big = a_big ? a[SIGN_BIT] : b[SIGN_BIT];
        s_sm  = a_big ? b[SIGN_BIT] : a[SIGN_BIT];

        shift   = e_big - e_sm;
        m_sm_al = (shift >= 5'd12) ? 11'd0 : (m_sm >> shift);

        if (s_big == s_sm) raw = {1'b0, m_big} + {1'b0, m_sm_al};
        else               raw = {1'b0, m_big} - {1'b0, m_sm_al};

        msb = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (raw[i]) msb = 4'(i);
        end
        lz   = 4'd10 - msb;
        norm = raw[10:0] << lz;

        if (raw[11]) begin
            exp_n = $signed({2'b00, e_big}) + 7'sd1;
            man   = raw[10:1];
        end else begin
            exp_n = $signed({2'b00, e_big}) - $signed({3'b000, lz});
            man   = norm[9:0];
        end

        if (raw == 12'd0 || exp_n < 7'sd1) s = FP16_ZERO;
        else if (exp_n > 7'sd30)           s = {s_big, FP16_MAXPOS[14:0]};
        else                               s = {s_big, exp_n[4:0], man};
    end

endmodule

// File: rtl/fp16_accum_stream.sv
// Sums N_TERMS fp16 products one per cycle and holds the result on a
// valid/ready output until the activation stage takes it.
module fp16_accum_stream
    import fp16_pkg::*;
#(
    parameter int N_TERMS = 25,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] sum_out,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    acc_state_e       state_q, state_d;
    logic [15:0]      acc_q, acc_d, sum_q, sum_d, add_a, add_s;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;

    // The first term of a window is added to zero, not to a stale acc
    assign add_a = (state_q == IDLE) ? FP16_ZERO : acc_q;

    fp16_add_core u_add (
        .a (add_a),
        .b (in_data),
        .s (add_s)
    );

    assign in_ready  = (state_q != HOLD);
    assign sum_out   = sum_q;
    assign out_valid = valid_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = FP16_ZERO;
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    acc_d   = add_s;
                    count_d = CNT_W'(1);
                    if (N_TERMS == 1) begin
                        sum_d   = add_s;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = ACCUM;
                    end
                end
                ACCUM: if (in_valid) begin
                    acc_d   = add_s;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST) begin
                        sum_d   = add_s;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: if (out_ready) begin
                    valid_d = 1'b0;
                    count_d = '0;
                    acc_d   = FP16_ZERO;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= FP16_ZERO;
            count_q <= '0;
            sum_q   <= FP16_ZERO;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_fp16_accum_stream.sv
// Directed bench for fp16_accum_stream with N_TERMS=4; inputs change and
// outputs are sampled on the falling edge.
module tb_fp16_accum_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] sum_out;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp16_accum_stream #(.N_TERMS(4), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_out   (sum_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one term for one cycle; the falling edge after acceptance is returned.
    task automatic push(input logic [15:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic get_result(input string tag, input logic [15:0] exp);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
        chk({tag, "_valid"}, 16'(out_valid), 16'h1);
        chk({tag, "_sum"}, sum_out, exp);
        $display("result %s sum_out=%h expected=%h", tag, sum_out, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle"}, 16'(in_ready), 16'h1);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 16'(in_ready), 16'h1);
        chk("rst_valid", 16'(out_valid), 16'h0);
        chk("rst_sum", sum_out, 16'h0000);
        reset = 1'b0;
        @(negedge clk);

        // Four ones back-to-back
        push(16'h3C00); push(16'h3C00); push(16'h3C00);
        chk("lat_valid_low", 16'(out_valid), 16'h0);
        push(16'h3C00);
        chk("t1_valid", 16'(out_valid), 16'h1);
        chk("t1_sum", sum_out, 16'h4400);
        chk("t1_ready_low", 16'(in_ready), 16'h0);
        get_result("t1", 16'h4400);
        chk("t1_valid_cleared", 16'(out_valid), 16'h0);

        // 1 + (-1) must leave a positive zero
        push(16'h3C00); push(16'hBC00);
        chk("t2_acc_pos_zero", dut.acc_q, 16'h0000);
        push(16'h4000); push(16'h3800);
        get_result("t2", 16'h4100);

        // Gapped input
        push(16'h0000); in_valid = 1'b0; @(negedge clk); @(negedge clk);
        push(16'h4200); in_valid = 1'b0; @(negedge clk); @(negedge clk);
        push(16'h0000); in_valid = 1'b0; @(negedge clk); @(negedge clk);
        chk("t3_not_done", 16'(out_valid), 16'h0);
        push(16'h0000);
        get_result("t3", 16'h4200);

        push(16'h7BFF); push(16'h7BFF); push(16'h7BFF); push(16'h7BFF);
        get_result("sat_pos", 16'h7BFF);
        push(16'hFBFF); push(16'hFBFF); push(16'hFBFF); push(16'hFBFF);
        get_result("sat_neg", 16'hFBFF);
        push(16'h0400); push(16'h8400); push(16'h0000); push(16'h0000);
        get_result("cancel", 16'h0000);

        // Backpressure with a pending upstream term
        push(16'h3C00); push(16'h3C00); push(16'h3C00); push(16'h3C00);
        in_data = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_sum", sum_out, 16'h4400);
            chk("bp_ready", 16'(in_ready), 16'h0);
            chk("bp_valid", 16'(out_valid), 16'h1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_valid", 16'(out_valid), 16'h0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        get_result("bp_next", 16'h4800);

        // Async reset mid-window
        push(16'h3C00); push(16'h3C00);
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 16'(out_valid), 16'h0);
        chk("mid_rst_sum", sum_out, 16'h0000);
        chk("mid_rst_ready", 16'(in_ready), 16'h1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Clear with a simultaneous term: that term is dropped
        push(16'h3C00); push(16'h3C00);
        in_data  = 16'h4000;
        in_valid = 1'b1;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_valid", 16'(out_valid), 16'h0);
        chk("clr_ready", 16'(in_ready), 16'h1);
        chk("clr_sum", sum_out, 16'h0000);
        chk("clr_acc", dut.acc_q, 16'h0000);
        @(negedge clk);
        push(16'h3C00); push(16'h3C00); push(16'h3C00); push(16'h3C00);
        get_result("fresh", 16'h4400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
